thermo_bargraph_ctrl: RTL and testbench
=======================================

// Module: thermo_bargraph_ctrl
// PURPOSE
//  Sequencer for the thermometer-to-bargraph decoder. Filters raw 4-bit thermometer samples,
//  grants/limits turbo mode, and drives the decoder's Thermo_in/Turbo_in.
//  Detects malformed codes and holds a fault state until cleared.
// PARAMETERS
//  STABLE_CNT  4   consecutive identical valid samples required before thermo_out updates (>=1)
//  TURBO_MAX   16  maximum cycles turbo_out may stay asserted per grant
//  COOL_CYC    8   cycles turbo is blocked after a turbo grant ends
//  FAULT_CNT   3   consecutive invalid samples that force FAULT
// PORTS
//  clk          in   1  single clock, rising edge
//  rst          in   1  synchronous, active-high reset
//  sample_valid in   1  sample_level is valid this cycle
//  sample_level in   4  raw thermometer code from sensor
//  turbo_req    in   1  level request for turbo mode
//  clear_fault  in   1  single-cycle pulse, leaves FAULT
//  thermo_out   out  4  filtered code -> decoder Thermo_in
//  turbo_out    out  1  -> decoder Turbo_in
//  fault        out  1  high while in FAULT
//  state_out    out  3  current FSM state encoding (debug)
// BEHAVIOUR
//  Reset: thermo_out=4'b0000, turbo_out=0, fault=0, state=IDLE; all counters cleared.
//  All outputs are registered.
//  Valid codes: 0000,0001,0011,0111,1111; all other values are invalid.
//  Filter:
//   - cand register with run counter.
//   - valid sample equal to cand: run++ (saturating at STABLE_CNT).
//   - valid sample differing from cand: cand=sample, run=1.
//   - when run reaches STABLE_CNT, thermo_out<=cand on the next edge (latency STABLE_CNT+1 cycles
//     from the first sample of the run).
//   - sample_valid=0: hold cand and run.
//   - invalid sample: run=0, cand kept, bad_cnt++.
//   - any valid sample clears bad_cnt.
//  States: IDLE=0, NORMAL=1, TURBO=2, COOL=3, FAULT=4.
//   - IDLE->NORMAL when thermo_out is first updated after reset.
//   - NORMAL->TURBO when turbo_req=1 and thermo_out!=1111.
//     turbo_out=1 from the cycle after entry.
//     turbo_tmr loads TURBO_MAX.
//   - TURBO->COOL when turbo_req=0, or thermo_out==1111, or turbo_tmr expires
//     (turbo_out high for exactly TURBO_MAX cycles max). turbo_out=0 in COOL.
//   - COOL->NORMAL after COOL_CYC cycles. turbo_req is ignored in COOL.
//   - any state->FAULT when bad_cnt reaches FAULT_CNT.
//     FAULT has priority over every other transition.
//     In FAULT: thermo_out=0000, turbo_out=0, fault=1; the filter is frozen.
//   - FAULT->IDLE on clear_fault. The filter and bad_cnt reset on exit.
//     clear_fault outside FAULT is ignored.
//  Simultaneous events:
//   - turbo_req drop and timer expiry in the same cycle -> COOL (single transition).
//   - invalid-sample fault beats a turbo grant in the same cycle.
//  rst asserted mid-turbo: turbo_out drops on the next edge; the full reset state applies.
//  Counters saturate; there is no wrap-around. Width = $clog2(max param + 1).
// STRUCTURE
//  thermo_pkg.vh: state localparams, valid-code constants, default parameter values.
//  Sub-module thermo_filter: code validation, cand/run/bad_cnt, emits upd and bad_limit.
//  The top level holds the FSM, turbo_tmr and cool_tmr. It instantiates the decoder only in the
//  bench, not in this block.
// TESTING
//  1 rst 2 cycles, 4 valid samples of 0011 -> thermo_out=0011 on cycle 5; state NORMAL.
//  2 0011,0011,0111,0011x4 -> thermo_out never shows 0111; final value 0011.
//  3 thermo_out=0011, turbo_req held 1 -> turbo_out high exactly 16 cycles, then 8 cycles COOL,
//    then re-grant.
//  4 in TURBO, filtered level reaches 1111 -> turbo_out=0 next cycle; state COOL.
//  5 samples 0101,1010,0110 -> fault=1, thermo_out=0000; clear_fault pulse -> IDLE, fault=0.
//  6 rst mid-TURBO -> next edge: turbo_out=0, thermo_out=0000, state IDLE.

Source files
------------

// File: rtl/thermo_bargraph_ctrl_pkg.sv
// rtl/thermo_bargraph_ctrl_pkg.sv - shared states, code constants and defaults for the bargraph sequencer
package thermo_bargraph_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_NORMAL = 3'd1,
        ST_TURBO  = 3'd2,
        ST_COOL   = 3'd3,
        ST_FAULT  = 3'd4
    } state_t;

    localparam logic [3:0] CODE_L0 = 4'b0000;
    localparam logic [3:0] CODE_L1 = 4'b0001;
    localparam logic [3:0] CODE_L2 = 4'b0011;
    localparam logic [3:0] CODE_L3 = 4'b0111;
    localparam logic [3:0] CODE_L4 = 4'b1111;

    localparam int STABLE_CNT_DEF = 4;
    localparam int TURBO_MAX_DEF  = 16;
    localparam int COOL_CYC_DEF   = 8;
    localparam int FAULT_CNT_DEF  = 3;

    function automatic logic is_valid_code(input logic [3:0] code);
        return (code == CODE_L0) || (code == CODE_L1) || (code == CODE_L2) ||
               (code == CODE_L3) || (code == CODE_L4);
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/thermo_bargraph_ctrl_if.sv
// rtl/thermo_bargraph_ctrl_if.sv - sensor/request inputs and decoder-side outputs of the sequencer
interface thermo_bargraph_ctrl_if;
    logic       sample_valid;
    logic [3:0] sample_level;
    logic       turbo_req;
    logic       clear_fault;
    logic [3:0] thermo_out;
    logic       turbo_out;
    logic       fault;
    logic [2:0] state_out;

    modport master (
        output sample_valid, sample_level, turbo_req, clear_fault,
        input  thermo_out, turbo_out, fault, state_out
    );

    modport slave (
        input  sample_valid, sample_level, turbo_req, clear_fault,
        output thermo_out, turbo_out, fault, state_out
    );
endinterface

// File: rtl/thermo_bargraph_ctrl_filter.sv
// rtl/thermo_bargraph_ctrl_filter.sv - code validation and run-length debounce of raw thermometer samples
module thermo_bargraph_ctrl_filter
    import thermo_bargraph_ctrl_pkg::*;
#(
    parameter int STABLE_CNT = STABLE_CNT_DEF,
    parameter int FAULT_CNT  = FAULT_CNT_DEF,
    parameter int CNT_W      = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    input  logic       sample_valid,
    input  logic [3:0] sample_level,
    output logic [3:0] cand,
    output logic       upd,
    output logic       bad_limit
);

    logic [CNT_W-1:0] run;
    logic [CNT_W-1:0] bad_cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cand    <= CODE_L0;
            run     <= '0;
            bad_cnt <= '0;
        end else if (en && sample_valid) begin
            if (is_valid_code(sample_level)) begin
                bad_cnt <= '0;
                if (sample_level == cand) begin
                    if (run < CNT_W'(STABLE_CNT)) run <= run + 1'b1;
                end else begin
                    cand <= sample_level;
                    run  <= CNT_W'(1);
                end
            end else begin
                // a bad sample breaks the run but keeps the candidate code
                run <= '0;
                if (bad_cnt < CNT_W'(FAULT_CNT)) bad_cnt <= bad_cnt + 1'b1;
            end
        end
    end

    assign upd       = (run == CNT_W'(STABLE_CNT));
    assign bad_limit = (bad_cnt == CNT_W'(FAULT_CNT));

endmodule

// File: rtl/thermo_bargraph_ctrl.sv
// rtl/thermo_bargraph_ctrl.sv - turbo/fault sequencer driving the bargraph decoder inputs
module thermo_bargraph_ctrl
    import thermo_bargraph_ctrl_pkg::*;
#(
    parameter int STABLE_CNT = STABLE_CNT_DEF,
    parameter int TURBO_MAX  = TURBO_MAX_DEF,
    parameter int COOL_CYC   = COOL_CYC_DEF,
    parameter int FAULT_CNT  = FAULT_CNT_DEF
) (
    input logic                   clk,
    input logic                   rst,
    thermo_bargraph_ctrl_if.slave bus
);

    localparam int CNT_W = $clog2(max4(STABLE_CNT, TURBO_MAX, COOL_CYC, FAULT_CNT) + 1);

    state_t           state_q, state_d;
    logic [3:0]       thermo_q, thermo_d;
    logic             turbo_q, turbo_d;
    logic             fault_q, fault_d;
    logic [CNT_W-1:0] turbo_tmr, cool_tmr;
    logic [3:0]       cand;
    logic             upd, bad_limit;

    thermo_bargraph_ctrl_filter #(
        .STABLE_CNT(STABLE_CNT),
        .FAULT_CNT (FAULT_CNT),
        .CNT_W     (CNT_W)
    ) u_filter (
        .clk         (clk),
        .rst         (rst),
        .en          (state_q != ST_FAULT),
        .clr         ((state_q == ST_FAULT) && bus.clear_fault),
        .sample_valid(bus.sample_valid),
        .sample_level(bus.sample_level),
        .cand        (cand),
        .upd         (upd),
        .bad_limit   (bad_limit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            thermo_q <= CODE_L0;
            turbo_q  <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            thermo_q <= thermo_d;
            turbo_q  <= turbo_d;
            fault_q  <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q != ST_FAULT && bad_limit) begin
            state_d = ST_FAULT;
        end else begin
            case (state_q)
                ST_IDLE:   if (upd) state_d = ST_NORMAL;
                ST_NORMAL: if (bus.turbo_req && thermo_q != CODE_L4) state_d = ST_TURBO;
                ST_TURBO:  if (!bus.turbo_req || thermo_q == CODE_L4 ||
                               turbo_tmr <= CNT_W'(1)) state_d = ST_COOL;
                ST_COOL:   if (cool_tmr <= CNT_W'(1)) state_d = ST_NORMAL;
                ST_FAULT:  if (bus.clear_fault) state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        turbo_d  = (state_d == ST_TURBO);
        fault_d  = (state_d == ST_FAULT);
        thermo_d = thermo_q;
        // the level stays blanked on the way out of FAULT until the reset filter re-qualifies
        if (state_d == ST_FAULT || state_q == ST_FAULT) thermo_d = CODE_L0;
        else if (upd)                                    thermo_d = cand;
    end

    // timers preload while idle in other states and count down from the first cycle inside
    always_ff @(posedge clk) begin
        if (rst) begin
            turbo_tmr <= '0;
            cool_tmr  <= '0;
        end else begin
            if (state_q != ST_TURBO)  turbo_tmr <= CNT_W'(TURBO_MAX);
            else if (turbo_tmr != '0) turbo_tmr <= turbo_tmr - 1'b1;
            if (state_q != ST_COOL)   cool_tmr  <= CNT_W'(COOL_CYC);
            else if (cool_tmr != '0)  cool_tmr  <= cool_tmr - 1'b1;
        end
    end

    assign bus.thermo_out = thermo_q;
    assign bus.turbo_out  = turbo_q;
    assign bus.fault      = fault_q;
    assign bus.state_out  = state_q;

endmodule

// File: tb/tb_thermo_bargraph_ctrl.sv
// tb/tb_thermo_bargraph_ctrl.sv - scoreboard bench for thermo_bargraph_ctrl
module tb_thermo_bargraph_ctrl;
    import thermo_bargraph_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    thermo_bargraph_ctrl_if bus();

    thermo_bargraph_ctrl dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int         cyc;
        logic [3:0] thermo;
        logic       turbo;
        logic       fault;
        logic [2:0] state;
        string      name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   edge_cnt = 0;
    int   checks   = 0;
    int   errors   = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic expect_out(input int n, input logic [3:0] t, input logic tu,
                              input logic f, input state_t s, input string name);
        exp_t e;
        e.cyc    = edge_cnt + n;
        e.thermo = t;
        e.turbo  = tu;
        e.fault  = f;
        e.state  = s;
        e.name   = name;
        sb.push_back(e);
    endtask

    task automatic cyc_in(input logic v, input logic [3:0] l, input logic req, input logic clr);
        bus.sample_valid = v;
        bus.sample_level = l;
        bus.turbo_req    = req;
        bus.clear_fault  = clr;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= edge_cnt) begin
            mon_e  = sb.pop_front();
            checks = checks + 1;
            if (mon_e.cyc != edge_cnt ||
                {bus.thermo_out, bus.turbo_out, bus.fault, bus.state_out} !=
                {mon_e.thermo, mon_e.turbo, mon_e.fault, mon_e.state}) begin
                errors = errors + 1;
                $display("FAIL %s @edge %0d: got thermo=%b turbo=%b fault=%b state=%0d, want thermo=%b turbo=%b fault=%b state=%0d",
                         mon_e.name, edge_cnt, bus.thermo_out, bus.turbo_out, bus.fault, bus.state_out,
                         mon_e.thermo, mon_e.turbo, mon_e.fault, mon_e.state);
            end
        end
    end

    initial begin
        // 1: reset, then four 0011 samples qualify on the fifth edge
        rst = 1'b1;
        cyc_in(0, 4'b0000, 0, 0);
        cyc_in(0, 4'b0000, 0, 0);
        rst = 1'b0;
        expect_out(0, 4'b0000, 0, 0, ST_IDLE, "reset_state");
        for (int i = 0; i < 4; i++) cyc_in(1, 4'b0011, 0, 0);
        expect_out(0, 4'b0000, 0, 0, ST_IDLE,   "t1_latency");
        expect_out(1, 4'b0011, 0, 0, ST_NORMAL, "t1_update");
        cyc_in(0, 4'b0000, 0, 0);

        // 2: a one-sample glitch to 0111 never reaches the output
        rst = 1'b1;
        cyc_in(0, 4'b0000, 0, 0);
        rst = 1'b0;
        cyc_in(1, 4'b0011, 0, 0); expect_out(0, 4'b0000, 0, 0, ST_IDLE, "t2_s1");
        cyc_in(1, 4'b0011, 0, 0); expect_out(0, 4'b0000, 0, 0, ST_IDLE, "t2_s2");
        cyc_in(1, 4'b0111, 0, 0); expect_out(0, 4'b0000, 0, 0, ST_IDLE, "t2_glitch");
        for (int i = 0; i < 4; i++) begin
            cyc_in(1, 4'b0011, 0, 0);
            expect_out(0, 4'b0000, 0, 0, ST_IDLE, "t2_rerun");
        end
        expect_out(1, 4'b0011, 0, 0, ST_NORMAL, "t2_final");
        cyc_in(0, 4'b0000, 0, 0);

        // 3: held turbo request: 16 cycles on, 8 cool, one NORMAL, re-grant
        cyc_in(0, 4'b0000, 1, 0);
        for (int i = 0; i < 16; i++) expect_out(i, 4'b0011, 1, 0, ST_TURBO, "t3_turbo_on");
        for (int i = 16; i < 24; i++) expect_out(i, 4'b0011, 0, 0, ST_COOL, "t3_cool");
        expect_out(24, 4'b0011, 0, 0, ST_NORMAL, "t3_normal_gap");
        expect_out(25, 4'b0011, 1, 0, ST_TURBO,  "t3_regrant");
        for (int i = 0; i < 25; i++) cyc_in(0, 4'b0000, 1, 0);

        // 4: level reaching 1111 during turbo ends the grant one cycle later
        for (int i = 0; i < 4; i++) cyc_in(1, 4'b1111, 1, 0);
        expect_out(1, 4'b1111, 1, 0, ST_TURBO, "t4_full_seen");
        expect_out(2, 4'b1111, 0, 0, ST_COOL,  "t4_turbo_drop");
        cyc_in(0, 4'b0000, 1, 0);
        cyc_in(0, 4'b0000, 1, 0);

        // 5: three malformed codes -> FAULT, filter frozen, clear returns to IDLE
        cyc_in(1, 4'b0101, 0, 0);
        cyc_in(1, 4'b1010, 0, 0);
        cyc_in(1, 4'b0110, 0, 0);
        expect_out(1, 4'b0000, 0, 1, ST_FAULT, "t5_fault_entry");
        for (int i = 0; i < 5; i++) begin
            cyc_in(1, 4'b0011, 0, 0);
            expect_out(0, 4'b0000, 0, 1, ST_FAULT, "t5_frozen");
        end
        cyc_in(0, 4'b0000, 0, 1);
        expect_out(0, 4'b0000, 0, 0, ST_IDLE, "t5_cleared");
        cyc_in(1, 4'b0011, 0, 1);
        expect_out(0, 4'b0000, 0, 0, ST_IDLE, "t5_clear_ignored");

        // 6: reset in the middle of a turbo grant
        for (int i = 0; i < 3; i++) cyc_in(1, 4'b0011, 0, 0);
        cyc_in(0, 4'b0000, 1, 0);
        expect_out(0, 4'b0011, 0, 0, ST_NORMAL, "t6_normal");
        cyc_in(0, 4'b0000, 1, 0);
        expect_out(0, 4'b0011, 1, 0, ST_TURBO, "t6_turbo");
        rst = 1'b1;
        cyc_in(0, 4'b0000, 1, 0);
        expect_out(0, 4'b0000, 0, 0, ST_IDLE, "t6_reset");
        rst = 1'b0;
        cyc_in(0, 4'b0000, 1, 0);
        expect_out(0, 4'b0000, 0, 0, ST_IDLE, "t6_req_in_idle");

        // 7: a valid sample clears the bad count; only three in a row fault
        cyc_in(1, 4'b1001, 0, 0);
        cyc_in(1, 4'b1001, 0, 0);
        cyc_in(1, 4'b0011, 0, 0);
        cyc_in(1, 4'b1001, 0, 0);
        cyc_in(1, 4'b1001, 0, 0);
        expect_out(1, 4'b0000, 0, 0, ST_IDLE, "t7_bad_reset");
        cyc_in(1, 4'b1001, 0, 0);
        expect_out(1, 4'b0000, 0, 1, ST_FAULT, "t7_fault");
        cyc_in(0, 4'b0000, 0, 1);
        cyc_in(0, 4'b0000, 0, 0);
        expect_out(0, 4'b0000, 0, 1, ST_FAULT, "t7_hold");
        cyc_in(0, 4'b0000, 0, 1);
        expect_out(0, 4'b0000, 0, 0, ST_IDLE, "t7_cleared");

        for (int i = 0; i < 100 && sb.size() > 0; i++) cyc_in(0, 4'b0000, 0, 0);
        cyc_in(0, 4'b0000, 0, 0);
        if (sb.size() != 0) begin
            errors = errors + sb.size();
            $display("FAIL drain: %0d expectations never checked, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
